// File: rtl/gn_clk_en_sched.sv
// gn_clk_en_sched: per-channel programmable clock-enable ticks with req/ack start and drain-to-period-end stop.
// The stop path lets every enabled channel finish its current period, so no tick period is ever cut short.
module gn_clk_en_sched #(
    parameter int P_NUM_CH = 4,
    parameter int P_DIV_W  = 16,
    localparam int CW      = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [P_DIV_W-1:0]  cfg_div,
    output logic                cfg_err,
    input  logic                run_req,
    output logic                run_ack,
    output logic                busy,
    output logic [P_NUM_CH-1:0] tick
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t state_q, state_d;
    logic [P_DIV_W-1:0] div_q [P_NUM_CH];
    logic [P_DIV_W-1:0] cnt_q [P_NUM_CH];
    logic [P_DIV_W-1:0] cnt_d [P_NUM_CH];
    logic [P_NUM_CH-1:0] done_q, done_d, en, term;
    logic run_ack_q, busy_q, cfg_err_q, ch_ok;

    assign ch_ok   = int'(cfg_ch) < P_NUM_CH;
    assign run_ack = run_ack_q;
    assign busy    = busy_q;
    assign cfg_err = cfg_err_q;

    always_comb begin
        for (int c = 0; c < P_NUM_CH; c++) begin
            en[c]   = div_q[c] != '0;
            term[c] = en[c] && (cnt_q[c] == div_q[c] - P_DIV_W'(1));
            tick[c] = term[c] && (state_q == RUN || (state_q == STOP && !done_q[c]));
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (run_req) begin
                state_d = RUN;
                done_d  = '0;
                for (int c = 0; c < P_NUM_CH; c++) cnt_d[c] = '0;
            end
        end else if (state_q == RUN) begin
            for (int c = 0; c < P_NUM_CH; c++)
                cnt_d[c] = (!en[c] || term[c]) ? '0 : cnt_q[c] + P_DIV_W'(1);
            if (!run_req) state_d = STOP;
        end else begin
            // A channel freezes after its final tick; the vacuous all-done case exits after one STOP cycle.
            for (int c = 0; c < P_NUM_CH; c++) begin
                if (en[c] && !done_q[c]) begin
                    done_d[c] = term[c];
                    cnt_d[c]  = term[c] ? cnt_q[c] : cnt_q[c] + P_DIV_W'(1);
                end
            end
            if (&(done_d | ~en)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            done_q    <= '0;
            run_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int c = 0; c < P_NUM_CH; c++) begin
                div_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            run_ack_q <= state_d == RUN;
            busy_q    <= state_d != IDLE;
            cfg_err_q <= cfg_we && (state_q != IDLE || !ch_ok);
            for (int c = 0; c < P_NUM_CH; c++)
                if (cfg_we && state_q == IDLE && cfg_ch == CW'(c)) div_q[c] <= cfg_div;
        end
    end
endmodule

// File: tb/tb_gn_clk_en_sched.sv
// tb_gn_clk_en_sched: directed checks of divide, drain, config guard, restart and extreme divisors.
module tb_gn_clk_en_sched;
    localparam int NCH = 5;
    localparam int DW  = 4;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_we = 1'b0;
    logic [2:0]     cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic           cfg_err, run_req = 1'b0, run_ack, busy;
    logic [NCH-1:0] tick;
    logic [DW-1:0]  mdiv [NCH];
    logic [NCH-1:0] acc;
    int total = 0, bad = 0, k = 0;

    gn_clk_en_sched #(.P_NUM_CH(NCH), .P_DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .run_req(run_req), .run_ack(run_ack), .busy(busy), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH-1:0] exp_tick(input int cyc);
        logic [NCH-1:0] t;
        for (int c = 0; c < NCH; c++) t[c] = (mdiv[c] != 0) && (cyc % int'(mdiv[c]) == 0);
        return t;
    endfunction

    task automatic step_check(input string tag);
        check(tag, 32'(tick), 32'(exp_tick(k)));
        k++;
        @(negedge clk);
    endtask

    task automatic set_div(input int ch, input int dv, input logic err);
        cfg_we = 1'b1;
        cfg_ch = 3'(ch);
        cfg_div = DW'(dv);
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err_idle", 32'(cfg_err), 32'(err));
        if (!err) mdiv[ch] = DW'(dv);
    endtask

    task automatic start_run;
        run_req = 1'b1;
        @(negedge clk);
        k = 1;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) mdiv[c] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_tick", 32'(tick), 0);
        check("rst_ack", 32'(run_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(cfg_err), 0);
        // divide: 1,2,3,0,0
        set_div(0, 1, 1'b0);
        set_div(1, 2, 1'b0);
        set_div(2, 3, 1'b0);
        set_div(3, 0, 1'b0);
        set_div(4, 0, 1'b0);
        start_run;
        check("run_ack", 32'(run_ack), 1);
        check("run_busy", 32'(busy), 1);
        for (int i = 0; i < 12; i++) step_check("div_tick");
        // config write during RUN is rejected
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 4'd9;
        step_check("guard_tick");
        cfg_we = 1'b0;
        check("guard_err", 32'(cfg_err), 1);
        step_check("guard_tick");
        check("guard_err_clr", 32'(cfg_err), 0);
        step_check("guard_tick");
        step_check("guard_tick");
        // reset mid-RUN
        rst = 1'b1;
        run_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) mdiv[c] = '0;
        check("midrst_tick", 32'(tick), 0);
        check("midrst_ack", 32'(run_ack), 0);
        check("midrst_busy", 32'(busy), 0);
        start_run;
        check("alloff_ack", 32'(run_ack), 1);
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            acc |= tick;
            @(negedge clk);
        end
        check("rst_div_zero", 32'(acc), 0);
        run_req = 1'b0;
        @(negedge clk);
        check("alloff_stop_busy", 32'(busy), 1);
        check("alloff_stop_ack", 32'(run_ack), 0);
        @(negedge clk);
        check("alloff_idle", 32'(busy), 0);
        // drain: div0=5, stop sampled at end of RUN cycle 7
        set_div(0, 5, 1'b0);
        start_run;
        for (k = 1; k <= 11; k++) begin
            check("drain_tick", 32'(tick[0]), 32'(k == 5 || k == 10));
            if (k >= 8 && k <= 10) check("drain_ack", 32'(run_ack), 0);
            check("drain_busy", 32'(busy), 32'(k != 11));
            if (k == 7) run_req = 1'b0;
            @(negedge clk);
        end
        // restart: stop at cycle 3, re-raise at cycle 4 (ignored in STOP)
        start_run;
        for (k = 1; k <= 17; k++) begin
            check("rs_tick", 32'(tick[0]), 32'(k == 5 || k == 11 || k == 16));
            if (k == 5) check("rs_stop_ack", 32'(run_ack), 0);
            if (k == 6) check("rs_idle_busy", 32'(busy), 0);
            if (k == 7) check("rs_rerun_ack", 32'(run_ack), 1);
            if (k == 16) check("rs_drain_busy", 32'(busy), 1);
            if (k == 17) check("rs_final_busy", 32'(busy), 0);
            if (k == 3 || k == 11) run_req = 1'b0;
            if (k == 4) run_req = 1'b1;
            @(negedge clk);
        end
        set_div(5, 7, 1'b1);
        // extremes: div0 = 15
        set_div(0, 15, 1'b0);
        start_run;
        for (int i = 0; i < 31; i++) step_check("max_tick");
        run_req = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("max_drain_idle", 32'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
